cp0_exc_unit: RTL and testbench

//  Coprocessor-0 for the P7 pipeline: the consumer of the ALU's overflow_real and of

---
 rtl/cp0_exc_unit_if.sv | 26 ++
 rtl/cp0_exc_unit.sv | 141 ++++++++++++++
 tb/tb_cp0_exc_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_if.sv
// CP0 side-band bus between the M stage and the exception unit.
// The master modport belongs to the pipeline, and the slave modport belongs to CP0.
interface cp0_exc_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  DOut, EPCOut, Req
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output DOut, EPCOut, Req
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 for the P7 pipeline.
// It holds SR, Cause, EPC and PRId, raises the flush request, captures the victim PC,
// and serves mfc0/mtc0 accesses.
// Optional macro CP0_COUNT_EN adds the Count(9) and Compare(11) timer, which drives HWInt[5].
module cp0_exc_unit #(
  parameter logic [31:0] PRID      = 32'h2021_0707,
  parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
  input logic             clk,
  input logic             reset,
  cp0_exc_unit_if.slave   bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  hwEff;
  logic        intReq;
  logic        excReq;
  logic        req;
  logic [4:0]  code;
  logic        wrEn;

  // A victim instruction never commits its mtc0, so writes are gated by Req.
  assign wrEn = bus.WE & ~req;

`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tiLive;

  // The timer free-runs, and a match latches TI until Compare is rewritten (the clear wins).
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    tiLive    = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
    ti_d      = tiLive;
    if (wrEn && bus.A2 == 5'd9) count_d = bus.DIn;
    if (wrEn && bus.A2 == 5'd11) begin
      compare_d = bus.DIn;
      ti_d      = 1'b0;
    end
    hwEff = {bus.HWInt[5] | tiLive, bus.HWInt[4:0]};
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`else
  assign hwEff = bus.HWInt;
`endif

  // The request is combinational and uses live interrupt lines, not the sampled IP.
  // An interrupt beats an exception and records code 0.
  always_comb begin
    intReq = ie_q & ~exl_q & (|(hwEff & im_q));
    excReq = ~exl_q & (bus.ExcCodeIn != 5'd0);
    req    = intReq | excReq;
    code   = intReq ? 5'd0 : bus.ExcCodeIn;
  end

  // Next state: an exception entry takes precedence over mtc0, and eret beats an SR write for EXL.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = hwEff;
    if (req) begin
      exl_d = 1'b1;
      exc_d = code;
      bd_d  = bus.BDIn;
      epc_d = bus.BDIn ? (bus.PC - 32'd4) : bus.PC;
    end else begin
      if (wrEn && bus.A2 == 5'd12) begin
        im_d  = bus.DIn[15:10];
        exl_d = bus.DIn[1];
        ie_d  = bus.DIn[0];
      end
      if (wrEn && bus.A2 == 5'd14) epc_d = bus.DIn;
      if (bus.EXLClr) exl_d = 1'b0;
    end
  end

  // Architectural CP0 registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= 6'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= 6'd0;
      exc_q <= 5'd0;
      epc_q <= EPC_RESET;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // The mfc0 read mux only sees registered state, so a write is visible from the next cycle.
  always_comb begin
    case (bus.A1)
      5'd12:   bus.DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   bus.DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      5'd14:   bus.DOut = epc_q;
      5'd15:   bus.DOut = PRID;
`ifdef CP0_COUNT_EN
      5'd9:    bus.DOut = count_q;
      5'd11:   bus.DOut = compare_q;
`endif
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.EPCOut = epc_q;
  assign bus.Req    = req;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
// The CP0_COUNT_EN timer section is compiled only when the macro is defined.
module tb_cp0_exc_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cp0_exc_unit_if bus ();

  cp0_exc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock with a 20 ns period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] a2, input logic [31:0] din,
                               input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                               input logic [5:0] hw, input logic exlClr);
    bus.WE        = we;
    bus.A2        = a2;
    bus.DIn       = din;
    bus.PC        = pc;
    bus.BDIn      = bd;
    bus.ExcCodeIn = exc;
    bus.HWInt     = hw;
    bus.EXLClr    = exlClr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.A1 = addr;
    #1;
    checkOutput(tag, bus.DOut, exp);
  endtask

  task automatic checkReq(input string tag, input logic exp);
    #1;
    checkOutput(tag, {31'd0, bus.Req}, {31'd0, exp});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.A1      = 5'd0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkReq("rst_req", 1'b0);
    checkOutput("rst_epcout", bus.EPCOut, 32'h0000_3000);
    readReg("rst_sr", 5'd12, 32'h0);
    readReg("rst_cause", 5'd13, 32'h0);
    readReg("rst_prid", 5'd15, 32'h2021_0707);
    readReg("rst_unmapped", 5'd3, 32'h0);

    // Overflow exception
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3010, 1'b0, 5'd12, 6'd0, 1'b0);
    checkReq("ov_req", 1'b1);
    tick();
    readReg("ov_cause", 5'd13, 32'h0000_0030);
    readReg("ov_epc", 5'd14, 32'h0000_3010);
    readReg("ov_sr", 5'd12, 32'h0000_0002);
    checkOutput("ov_epcout", bus.EPCOut, 32'h0000_3010);

    // While EXL is set, a nested exception is blocked and EPC holds its value.
    checkReq("nest_req", 1'b0);
    tick();
    readReg("nest_epc", 5'd14, 32'h0000_3010);

    // eret clears EXL.
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();
    idle();
    readReg("eret_sr", 5'd12, 32'h0);

    // Delay-slot exception
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3024, 1'b1, 5'd10, 6'd0, 1'b0);
    checkReq("bd_req", 1'b1);
    tick();
    idle();
    readReg("bd_epc", 5'd14, 32'h0000_3020);
    readReg("bd_cause", 5'd13, 32'h8000_0028);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // The victim's mtc0 to EPC is discarded.
    applyStimulus(1'b1, 5'd14, 32'hDEAD_BEEC, 32'h0000_4000, 1'b0, 5'd12, 6'd0, 1'b0);
    checkReq("victim_req", 1'b1);
    tick();
    idle();
    readReg("victim_epc", 5'd14, 32'h0000_4000);
    readReg("victim_cause", 5'd13, 32'h0000_0030);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // A delay slot at PC 0 wraps EPC to FFFF_FFFC.
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b1, 5'd4, 6'd0, 1'b0);
    tick();
    idle();
    readReg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    readReg("wrap_cause", 5'd13, 32'h8000_0010);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // Interrupt: the SR write has no bypass, so it becomes visible in the next cycle.
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    readReg("sr_nobypass", 5'd12, 32'h0);
    tick();
    readReg("sr_written", 5'd12, 32'h0000_0401);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_5000, 1'b0, 5'd0, 6'b000001, 1'b0);
    checkReq("int_req", 1'b1);
    tick();
    readReg("int_cause", 5'd13, 32'h0000_0400);
    readReg("int_sr", 5'd12, 32'h0000_0403);
    readReg("int_epc", 5'd14, 32'h0000_5000);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // An interrupt beats an exception in the same cycle.
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_6000, 1'b0, 5'd4, 6'b000001, 1'b0);
    checkReq("prio_req", 1'b1);
    tick();
    idle();
    readReg("prio_cause", 5'd13, 32'h0000_0400);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();

    // With IE=0, the interrupt is masked but IP still tracks the line.
    applyStimulus(1'b1, 5'd12, 32'h0000_0400, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'b000001, 1'b0);
    checkReq("ie0_req", 1'b0);
    tick();
    readReg("ie0_cause", 5'd13, 32'h0000_0400);
    readReg("ie0_sr", 5'd12, 32'h0000_0400);

    // eret beats an SR write that sets EXL.
    applyStimulus(1'b1, 5'd12, 32'h0000_0403, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();
    idle();
    readReg("exlclr_wins", 5'd12, 32'h0000_0401);
    checkReq("exlclr_req", 1'b0);

    // Cause is read-only, and writes to unmapped registers are ignored.
    applyStimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd3, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    idle();
    readReg("cause_ro", 5'd13, 32'h0);
    readReg("unmapped_wr", 5'd3, 32'h0);

    // SR keeps only IM, EXL and IE.
    applyStimulus(1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    idle();
    readReg("sr_mask", 5'd12, 32'h0000_FC03);

    // A reset in the middle of a handler restores everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'h3F, 1'b0);
    checkReq("midrst_req", 1'b0);
    readReg("midrst_sr", 5'd12, 32'h0);
    checkOutput("midrst_epc", bus.EPCOut, 32'h0000_3000);
    idle();
    tick();
    tick();

`ifdef CP0_COUNT_EN
    // Timer: Compare=5, Count=0, SR enables IM[15] and IE.
    begin
      int found;
      found = 0;
      applyStimulus(1'b1, 5'd11, 32'd5, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd9, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd12, 32'h0000_8001, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
      tick();
      idle();
      for (int i = 0; i < 20; i++) begin
        #1;
        if (bus.Req) begin
          found = 1;
          break;
        end
        tick();
      end
      checkOutput("ti_found", found, 32'd1);
      readReg("ti_count", 5'd9, 32'd5);
      tick();
      readReg("ti_cause", 5'd13, 32'h0000_8000);
      applyStimulus(1'b1, 5'd11, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
      tick();
      idle();
      checkReq("ti_cleared", 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
